// File: rtl/touch_point_rd_if.sv
// User-side command port of the I2C driver wrapper.
// master = touch reader, slave = driver wrapper.
interface touch_point_rd_if #(
   parameter int WIDTH = 8
);
   logic             i2c_exec;
   logic             i2c_rh_wl;
   logic [15:0]      i2c_addr;
   logic [7:0]       i2c_data_w;
   logic [WIDTH-1:0] reg_num;
   logic             bit_ctrl;
   logic [7:0]       i2c_data_r;
   logic             i2c_done;
   logic             once_done;

   modport master (
      output i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w, reg_num, bit_ctrl,
      input  i2c_data_r, i2c_done, once_done
   );

   modport slave (
      input  i2c_exec, i2c_rh_wl, i2c_addr, i2c_data_w, reg_num, bit_ctrl,
      output i2c_data_r, i2c_done, once_done
   );
endinterface

// File: rtl/touch_point_rd.sv
// Polling touch reader for GT9xx / FT5x06 panels: status poll, first-point XY read,
// GT status clear. Drives the I2C driver wrapper once register configuration is done.
//
// state     | meaning
// WAIT_CFG  | configuration block owns the bus, waiting for cfg_done
// POLL_WAIT | down-counting the poll interval
// RD_STAT   | reading the status byte
// CHK       | deciding on the status byte
// RD_XY     | reading four coordinate bytes of point 1
// CLR       | writing 0 to the GT status register
module touch_point_rd #(
   parameter int WIDTH          = 8,
   parameter int POLL_CYCLES    = 10000,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [15:0]           lcd_id,
   input  logic                  cfg_done,
   output logic                  cfg_switch,
   touch_point_rd_if.master      i2c,
   output logic [15:0]           tp_x,
   output logic [15:0]           tp_y,
   output logic                  touch_valid,
   output logic                  tp_flag
);
   localparam logic [2:0] WAIT_CFG  = 3'd0;
   localparam logic [2:0] POLL_WAIT = 3'd1;
   localparam logic [2:0] RD_STAT   = 3'd2;
   localparam logic [2:0] CHK       = 3'd3;
   localparam logic [2:0] RD_XY     = 3'd4;
   localparam logic [2:0] CLR       = 3'd5;

   localparam int PW = $clog2(POLL_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [PW-1:0] POLL_LOAD = PW'(POLL_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);

   logic [2:0]      state;
   logic [PW-1:0]   poll_cnt;
   logic [TW-1:0]   tmo_cnt;
   logic            issue;
   logic [7:0]      stat;
   logic [3:0][7:0] xy_b;
   logic [3:0][7:0] xy_nx;
   logic [1:0]      byte_idx;
   logic            xy_full;
   logic            ft_mode;
   logic            xfer_end;
   logic            xfer_abort;
   logic            unused_ok;

   assign ft_mode      = (lcd_id[15:8] == 8'h70) || (lcd_id[15:8] == 8'h19);
   assign i2c.bit_ctrl = ~ft_mode;
   assign xfer_end     = !issue && i2c.once_done;
   assign xfer_abort   = !issue && !i2c.once_done && (tmo_cnt == '0);
   assign unused_ok    = ^{lcd_id[7:0], stat[6:4]};

   // Merge a byte arriving this cycle so a coincident once_done sees it.
   always_comb begin
      xy_nx = xy_b;
      if (state == RD_XY && !issue && i2c.i2c_done && !xy_full)
         xy_nx[byte_idx] = i2c.i2c_data_r;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= WAIT_CFG;
         poll_cnt       <= '0;
         tmo_cnt        <= '0;
         issue          <= 1'b0;
         stat           <= '0;
         xy_b           <= '0;
         byte_idx       <= '0;
         xy_full        <= 1'b0;
         cfg_switch     <= 1'b0;
         i2c.i2c_exec   <= 1'b0;
         i2c.i2c_rh_wl  <= 1'b0;
         i2c.i2c_addr   <= '0;
         i2c.i2c_data_w <= '0;
         i2c.reg_num    <= '0;
         tp_x           <= '0;
         tp_y           <= '0;
         touch_valid    <= 1'b0;
         tp_flag        <= 1'b0;
      end else begin
         i2c.i2c_exec <= 1'b0;
         tp_flag      <= 1'b0;
         if (!issue && tmo_cnt != '0)
            tmo_cnt <= tmo_cnt - TW'(1);
         case (state)
            WAIT_CFG: begin
               if (cfg_done) begin
                  cfg_switch <= 1'b1;
                  state      <= POLL_WAIT;
                  poll_cnt   <= POLL_LOAD;
               end
            end
            POLL_WAIT: begin
               if (poll_cnt == '0) begin
                  state <= RD_STAT;
                  issue <= 1'b1;
               end else begin
                  poll_cnt <= poll_cnt - PW'(1);
               end
            end
            RD_STAT: begin
               if (issue) begin
                  issue          <= 1'b0;
                  i2c.i2c_exec   <= 1'b1;
                  i2c.i2c_rh_wl  <= 1'b1;
                  i2c.i2c_addr   <= ft_mode ? 16'h0002 : 16'h814E;
                  i2c.i2c_data_w <= 8'h00;
                  i2c.reg_num    <= WIDTH'(1);
                  tmo_cnt        <= TMO_LOAD;
               end else begin
                  if (i2c.i2c_done)
                     stat <= i2c.i2c_data_r;
                  if (xfer_end) begin
                     state <= CHK;
                  end else if (xfer_abort) begin
                     state    <= POLL_WAIT;
                     poll_cnt <= POLL_LOAD;
                  end
               end
            end
            CHK: begin
               if (ft_mode ? (stat[3:0] == 4'h0) : (stat[7] && stat[3:0] == 4'h0))
                  touch_valid <= 1'b0;
               if (ft_mode ? (stat[3:0] != 4'h0) : (stat[7] && stat[3:0] != 4'h0)) begin
                  state <= RD_XY;
                  issue <= 1'b1;
               end else if (!ft_mode && stat[7]) begin
                  state <= CLR;
                  issue <= 1'b1;
               end else begin
                  state    <= POLL_WAIT;
                  poll_cnt <= POLL_LOAD;
               end
            end
            RD_XY: begin
               if (issue) begin
                  issue          <= 1'b0;
                  i2c.i2c_exec   <= 1'b1;
                  i2c.i2c_rh_wl  <= 1'b1;
                  i2c.i2c_addr   <= ft_mode ? 16'h0003 : 16'h8150;
                  i2c.i2c_data_w <= 8'h00;
                  i2c.reg_num    <= WIDTH'(4);
                  tmo_cnt        <= TMO_LOAD;
                  byte_idx       <= '0;
                  xy_full        <= 1'b0;
               end else begin
                  xy_b <= xy_nx;
                  if (i2c.i2c_done && !xy_full) begin
                     if (byte_idx == 2'd3) xy_full  <= 1'b1;
                     else                  byte_idx <= byte_idx + 2'd1;
                  end
                  if (xfer_end) begin
                     tp_x        <= ft_mode ? {4'h0, xy_nx[0][3:0], xy_nx[1]} : {xy_nx[1], xy_nx[0]};
                     tp_y        <= ft_mode ? {4'h0, xy_nx[2][3:0], xy_nx[3]} : {xy_nx[3], xy_nx[2]};
                     touch_valid <= 1'b1;
                     tp_flag     <= 1'b1;
                     if (ft_mode) begin
                        state    <= POLL_WAIT;
                        poll_cnt <= POLL_LOAD;
                     end else begin
                        state <= CLR;
                        issue <= 1'b1;
                     end
                  end else if (xfer_abort) begin
                     state    <= POLL_WAIT;
                     poll_cnt <= POLL_LOAD;
                  end
               end
            end
            CLR: begin
               if (issue) begin
                  issue          <= 1'b0;
                  i2c.i2c_exec   <= 1'b1;
                  i2c.i2c_rh_wl  <= 1'b0;
                  i2c.i2c_addr   <= 16'h814E;
                  i2c.i2c_data_w <= 8'h00;
                  i2c.reg_num    <= WIDTH'(1);
                  tmo_cnt        <= TMO_LOAD;
               end else if (xfer_end || xfer_abort) begin
                  state    <= POLL_WAIT;
                  poll_cnt <= POLL_LOAD;
               end
            end
            default: state <= WAIT_CFG;
         endcase
      end
   end
endmodule

// File: doc/touch_point_rd.md
Name: touch_point_rd

Overview:
- Polling touch-read controller that sits directly upstream of the I2C configuration/driver wrapper; it drives that wrapper's user-side I2C command port (exec/rw/addr/data/reg_num) once register configuration completes.
- Periodically reads the controller status register and, on a fresh touch, reads the first touch point's X/Y coordinates.
- Publishes the coordinates to the LCD/UI logic and, for GT9xx parts, clears the status register.
- Supports GT9xx (16-bit register address) and FT5x06 (8-bit register address), selected by lcd_id.

Parameters:
- WIDTH, 8, width of reg_num bus; must match the driver wrapper.
- POLL_CYCLES, 10000, clk cycles between status polls (10 ms at 1 MHz clk_i2c).
- TIMEOUT_CYCLES, 50000, max clk cycles allowed from i2c_exec to once_done.

Ports:
- clk  input  1  I2C operation clock (the driver's clk_i2c, nominally 1 MHz).
- rst_n  input  1  reset, synchronous, active-low.
- lcd_id  input  16  panel ID; [15:8]==8'h70 or 8'h19 selects FT mode, otherwise GT mode.
- cfg_done  input  1  register configuration finished (level).
- i2c_exec  output  1  one-cycle transaction start pulse.
- i2c_rh_wl  output  1  1 = read, 0 = write.
- i2c_addr  output  16  register address.
- i2c_data_w  output  8  write data.
- reg_num  output  WIDTH  number of bytes in the transaction.
- bit_ctrl  output  1  1 = 16-bit register address (GT), 0 = 8-bit (FT).
- cfg_switch  output  1  0 = configuration block owns the bus, 1 = this block owns it.
- i2c_data_r  input  8  read byte, valid when i2c_done pulses.
- i2c_done  input  1  per-byte completion pulse.
- once_done  input  1  whole-transaction completion pulse.
- tp_x  output  16  X coordinate, zero-extended.
- tp_y  output  16  Y coordinate, zero-extended.
- touch_valid  output  1  level; 1 while the panel reports at least one point.
- tp_flag  output  1  one-cycle pulse when tp_x/tp_y are updated.

Behaviour:
- Reset (rst_n=0 at a clk edge) forces: all outputs 0, state WAIT_CFG, counters 0.
- Reset applies mid-transaction: outputs are cleared immediately; any in-flight once_done is ignored.
- bit_ctrl is combinational from lcd_id: 1 in GT mode, 0 in FT mode.
- FSM states and transitions:
  - WAIT_CFG: cfg_switch=0. When cfg_done=1, set cfg_switch=1 (sticky until reset) and go to POLL_WAIT.
  - POLL_WAIT: count to POLL_CYCLES-1, then go to RD_STAT.
  - RD_STAT: pulse i2c_exec with rh_wl=1 and reg_num=1. Address is 16'h814E in GT mode, 16'h0002 in FT mode. Latch the byte on i2c_done. On once_done go to CHK.
  - CHK, GT mode, status byte s:
    - s[7]=0: go to POLL_WAIT (no clear write).
    - s[7]=1 and s[3:0]==0: clear touch_valid, go to CLR.
    - s[7]=1 and s[3:0]>=1: go to RD_XY.
  - CHK, FT mode: s[3:0]==0 clears touch_valid and goes to POLL_WAIT; s[3:0]>=1 goes to RD_XY. FT mode never enters CLR.
  - RD_XY: read reg_num=4 starting at 16'h8150 (GT) or 16'h0003 (FT). Capture bytes b0..b3 in order of i2c_done pulses; a byte index counter selects the capture register.
  - RD_XY on once_done:
    - GT: x = {b1, b0}, y = {b3, b2}.
    - FT: x = {4'h0, b0[3:0], b1}, y = {4'h0, b2[3:0], b3}.
    - Register tp_x/tp_y, set touch_valid=1, pulse tp_flag for one cycle. Then go to CLR (GT) or POLL_WAIT (FT).
  - CLR: write reg_num=1 to 16'h814E with data 8'h00, rh_wl=0. On once_done go to POLL_WAIT.
- i2c_exec rules:
  - Asserted exactly one cycle per transaction, on entry to RD_STAT/RD_XY/CLR.
  - Never re-asserted before once_done or timeout.
  - i2c_addr, rh_wl, data_w and reg_num are held stable from the exec cycle until once_done.
- Timeout: a cycle counter starts at i2c_exec. Reaching TIMEOUT_CYCLES without once_done aborts to POLL_WAIT. tp_x, tp_y and touch_valid are left unchanged; no tp_flag is issued.
- Byte-count guard: more than 4 i2c_done pulses in RD_XY are ignored (index saturates at 3).
- Simultaneous i2c_done and once_done in the same cycle: the byte is captured first and is used in that once_done's result.
- Latency: tp_flag asserts 1 cycle after the RD_XY once_done.

Test Plan:
- Reset with cfg_done=1 held -> all outputs 0; cfg_switch=1 on the cycle after reset is released; first i2c_exec occurs POLL_CYCLES+1 cycles later with addr 16'h814E, rh_wl=1, reg_num=1.
- GT mode, status 8'h81, XY bytes 8'h20, 8'h01, 8'hE0, 8'h00 -> tp_x=16'h0120, tp_y=16'h00E0, touch_valid=1, one tp_flag; then a write to 16'h814E with data 8'h00.
- GT mode, status 8'h05 -> no XY read, no clear write; next exec occurs after POLL_CYCLES; outputs unchanged.
- GT mode, status 8'h80 after a touch -> touch_valid falls to 0 and the clear write is issued; tp_x/tp_y retain their last values.
- lcd_id=16'h7016, status 8'h01, bytes 8'h83, 8'h1F, 8'h41, 8'h0A -> bit_ctrl=0, read addr 16'h0003, tp_x=16'h031F, tp_y=16'h010A, no clear write.
- once_done withheld during RD_XY -> abort after TIMEOUT_CYCLES, no tp_flag, polling resumes; rst_n pulled low mid-RD_XY -> all outputs 0 on the next clk edge.
